// File: rtl/fir_sample_sequencer.sv
// FIR sample sequencer: replays a 32-entry sample buffer into an external FIR
// filter, then flushes it with zeros and drains the pipeline. Each filter
// result is captured and flagged so it lines up with the sample that caused it.
//
// Handshake: there is no backpressure. One sample is offered on o_fir_data_in
// in every RUN/FLUSH cycle, and the filter is assumed to take it. A result is
// presented as o_out_data for exactly one cycle, marked by o_out_valid=1.
// i_reset is asynchronous and active-low (0 = reset asserted).
module fir_sample_sequencer #(
    parameter int N    = 16,
    parameter int TAPS = 4,
    parameter int LAT  = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wr_en,
    input  logic [4:0]   i_wr_addr,
    input  logic [N-1:0] i_wr_data,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic         i_loop,
    input  logic [4:0]   i_len,
    output logic [N-1:0] o_fir_data_in,
    input  logic [N-1:0] i_fir_data_out,
    output logic [N-1:0] o_out_data,
    output logic         o_out_valid,
    output logic         o_busy,
    output logic         o_done,
    output logic [1:0]   o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // With a single tap there is nothing to flush, so RUN goes straight to DRAIN.
    localparam bit       HAS_FLUSH  = (TAPS > 1);
    localparam logic [7:0] FLUSH_LAST = 8'(TAPS - 2);

    state_t       r_state;
    logic [4:0]   r_ptr;
    logic [4:0]   r_len;
    logic         r_loop;
    logic [7:0]   r_flush_cnt;
    logic [N-1:0] r_fir_data_in;
    logic         r_done;
    logic [LAT:0] r_vsr;
    logic [N-1:0] r_out_data;
    logic [N-1:0] r_buf [32];

    logic         w_issue;
    logic [4:0]   w_ptr_nxt;
    logic [N-1:0] w_buf0;
    logic         w_wr_ok;

    assign w_issue   = (r_state == RUN) || (r_state == FLUSH);
    assign w_ptr_nxt = r_ptr + 5'd1;
    assign w_wr_ok   = i_wr_en && (r_state == IDLE);
    // A write to entry 0 in the start cycle must be seen by the first read.
    assign w_buf0    = (w_wr_ok && (i_wr_addr == 5'd0)) ? i_wr_data : r_buf[0];

    // Sample buffer; deliberately not reset, writes only while idle.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_buf[i_wr_addr] <= i_wr_data;
        end
    end

    // Sequencing FSM: pointer, issued sample, flush count and done pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_ptr         <= 5'd0;
            r_len         <= 5'd0;
            r_loop        <= 1'b0;
            r_flush_cnt   <= 8'd0;
            r_fir_data_in <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_fir_data_in <= '0;
                    if (i_start) begin
                        r_state       <= RUN;
                        r_ptr         <= 5'd0;
                        r_len         <= i_len;
                        r_loop        <= i_loop;
                        r_fir_data_in <= w_buf0;
                    end
                end
                RUN: begin
                    // Stop wins over wrap; the sample now on the bus was already issued.
                    if (i_stop || ((r_ptr == r_len) && !r_loop)) begin
                        r_fir_data_in <= '0;
                        r_flush_cnt   <= 8'd0;
                        r_state       <= HAS_FLUSH ? FLUSH : DRAIN;
                    end else if (r_ptr == r_len) begin
                        r_ptr         <= 5'd0;
                        r_fir_data_in <= r_buf[0];
                    end else begin
                        r_ptr         <= w_ptr_nxt;
                        r_fir_data_in <= r_buf[w_ptr_nxt];
                    end
                end
                FLUSH: begin
                    r_fir_data_in <= '0;
                    if (r_flush_cnt == FLUSH_LAST) begin
                        r_state <= DRAIN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    r_fir_data_in <= '0;
                    // Only the final result remains in flight: finish next cycle.
                    if (r_vsr[LAT-1:0] == '0) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_fir_data_in <= '0;
                end
            endcase
        end
    end

    // Valid tracking: one bit per issued sample, walking with filter latency.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_vsr <= '0;
        end else begin
            r_vsr <= {r_vsr[LAT-1:0], w_issue};
        end
    end

    // Capture the filter output the cycle it belongs to an issued sample.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_out_data <= '0;
        end else if (r_vsr[LAT-1]) begin
            r_out_data <= i_fir_data_out;
        end
    end

    assign o_fir_data_in = r_fir_data_in;
    assign o_out_data    = r_out_data;
    assign o_out_valid   = r_vsr[LAT];
    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed bench for fir_sample_sequencer with TAPS=4, LAT=2 and a filter
// modelled as a pure two-cycle delay.
module tb_fir_sample_sequencer;

  localparam int N    = 16;
  localparam int TAPS = 4;
  localparam int LAT  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [4:0]    wr_addr = '0;
  logic [N-1:0]  wr_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_m = 1'b0;
  logic [4:0]    len = '0;
  logic [N-1:0]  fir_data_in;
  logic [N-1:0]  fir_data_out;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  fir_sample_sequencer #(.N(N), .TAPS(TAPS), .LAT(LAT)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .i_start        (start),
    .i_stop         (stop),
    .i_loop         (loop_m),
    .i_len          (len),
    .o_fir_data_in  (fir_data_in),
    .i_fir_data_out (fir_data_out),
    .o_out_data     (out_data),
    .o_out_valid    (out_valid),
    .o_busy         (busy),
    .o_done         (done),
    .o_dbg_state    (dbg_state)
  );

  // Filter model: pure LAT-cycle delay of fir_data_in.
  logic [N-1:0] fir_d1 = '0;
  logic [N-1:0] fir_d2 = '0;
  always @(posedge clk) begin
    fir_d1 <= fir_data_in;
    fir_d2 <= fir_d1;
  end
  assign fir_data_out = fir_d2;

  // ---------------- scoreboard ----------------
  logic [N-1:0] buf_model [32];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_buf(input logic [4:0] a, input logic [N-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    buf_model[a] = d;
  endtask

  // Expected sample on fir_data_in in cycle c of a run (start in cycle 0).
  function automatic logic [N-1:0] exp_fir(input int c, input int slen, input int last_buf);
    if (c >= 1 && c <= last_buf) return buf_model[(c - 1) % (slen + 1)];
    return '0;
  endfunction

  // One sequence: start in cycle 0, issued samples in cycles 1..last_issue.
  // ign=1 adds ignored start/stop pulses and an ignored write.
  // fwd=1 writes 0x00AA to buf[0] in the start cycle itself.
  task automatic run_seq(input string nm, input int slen, input bit lp,
                         input int stop_c, input int last_issue,
                         input bit ign, input bit fwd);
    int last_buf;
    int ncyc;
    bit iss_m3;
    last_buf = last_issue - (TAPS - 1);
    ncyc = last_issue + 6;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == 0); stop = (c == stop_c); wr_en = 1'b0;
      len = 5'(slen); loop_m = lp;
      if (fwd && c == 0) begin
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'h00AA;
        buf_model[0] = 16'h00AA;
      end
      if (ign) begin
        if (c == 2 || c == 8) start = 1'b1;
        if (c == 6) stop = 1'b1;
        if (c == 3) begin wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'h0055; end
      end
      @(negedge clk);
      iss_m3 = (c - 3 >= 1) && (c - 3 <= last_issue);
      check({nm, ".fir"}, 32'(fir_data_in), 32'(exp_fir(c, slen, last_buf)));
      check({nm, ".valid"}, 32'(out_valid), 32'(iss_m3));
      if (iss_m3) check({nm, ".data"}, 32'(out_data), 32'(exp_fir(c - 3, slen, last_buf)));
      check({nm, ".done"}, 32'(done), 32'(c == last_issue + 4));
      check({nm, ".busy"}, 32'(busy), 32'(c >= 1 && c <= last_issue + 3));
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check("rst.fir", 32'(fir_data_in), 32'h0);
    check("rst.valid", 32'(out_valid), 32'h0);
    check("rst.data", 32'(out_data), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    check("rst.state", 32'(dbg_state), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 4; i++) write_buf(5'(i), 16'(i + 1));

    run_seq("basic", 3, 1'b0, -1, 7, 1'b0, 1'b0);
    run_seq("loop_stop", 3, 1'b1, 9, 12, 1'b0, 1'b0);
    run_seq("ignored", 3, 1'b0, -1, 7, 1'b1, 1'b0);

    // Reset asserted in cycle 3 of the basic scenario.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start = (c == 0); len = 5'd3; loop_m = 1'b0;
      @(negedge clk);
      check("abort.pre_fir", 32'(fir_data_in), 32'(c));
    end
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    #1;
    check("abort.fir", 32'(fir_data_in), 32'h0);
    check("abort.valid", 32'(out_valid), 32'h0);
    check("abort.data", 32'(out_data), 32'h0);
    check("abort.busy", 32'(busy), 32'h0);
    check("abort.done", 32'(done), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort.post_valid", 32'(out_valid), 32'h0);
      check("abort.post_done", 32'(done), 32'h0);
      check("abort.post_busy", 32'(busy), 32'h0);
    end
    run_seq("replay", 3, 1'b0, -1, 7, 1'b0, 1'b0);

    // len=0 with the buf[0] write in the same cycle as start.
    run_seq("single", 0, 1'b0, -1, 4, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
